// File: rtl/pi_uk_pkg.sv
// Shared constants and FSM state encodings for the pi_uk discrete PI controller.
package pi_uk_pkg;

    localparam int PI_N    = 18;
    localparam int PI_F    = 9;
    localparam int PI_MAXV = (32'sd1 <<< (PI_N - 1)) - 32'sd1;
    localparam int PI_MINV = -(32'sd1 <<< (PI_N - 1));

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULP  = 3'd1,
        ST_MULI  = 3'd2,
        ST_INTEG = 3'd3,
        ST_OUT   = 3'd4
    } pi_state_e;

endpackage

// File: rtl/pi_uk_fx_mul_sat.sv
// Combinational signed N x N multiply, floor shift by F, saturate back to N bits.
module fx_mul_sat
    import pi_uk_pkg::*;
#(
    parameter int N = PI_N,
    parameter int F = PI_F
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] y
);

    localparam logic signed [N-1:0] MAXV_L = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINV_L = {1'b1, {(N-1){1'b0}}};

    logic signed [2*N-1:0] ext_a;
    logic signed [2*N-1:0] ext_b;
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] shifted;
    logic        [N:0]     hi;

    // Full-width product; the result fits in N bits only if the top N+1 bits agree.
    always_comb begin
        ext_a   = {{N{a[N-1]}}, a};
        ext_b   = {{N{b[N-1]}}, b};
        prod    = ext_a * ext_b;
        shifted = prod >>> F;
        hi      = shifted[2*N-1:N-1];
        if ((hi == {(N+1){1'b0}}) || (hi == {(N+1){1'b1}})) begin
            y = shifted[N-1:0];
        end else if (shifted[2*N-1]) begin
            y = MINV_L;
        end else begin
            y = MAXV_L;
        end
    end

endmodule

// File: rtl/pi_uk.sv
// Discrete PI controller: one shared saturating multiplier sequenced by a five-state FSM,
// with an anti-windup clamped integrator and a saturated output.
module pi_uk
    import pi_uk_pkg::*;
#(
    parameter int N = PI_N,
    parameter int F = PI_F
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_tick,
    input  logic                int_clr,
    input  logic signed [N-1:0] ek,
    input  logic signed [N-1:0] kp,
    input  logic signed [N-1:0] ki,
    output logic signed [N-1:0] uk,
    output logic                uk_valid,
    output logic                busy
);

    localparam logic signed [N-1:0] MAXV_L = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINV_L = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0] ZERO_L = {N{1'b0}};

    // N+1-bit sum clamped to the N-bit range; overflow shows as the two top bits disagreeing.
    function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] x,
                                                    input logic signed [N-1:0] z);
        logic signed [N:0] s;
        s = {x[N-1], x} + {z[N-1], z};
        if (s[N] == s[N-1]) begin
            sat_add = s[N-1:0];
        end else if (s[N]) begin
            sat_add = MINV_L;
        end else begin
            sat_add = MAXV_L;
        end
    endfunction

    pi_state_e state_q, state_d;

    logic signed [N-1:0] ek_q, ek_d;
    logic signed [N-1:0] kp_q, kp_d;
    logic signed [N-1:0] ki_q, ki_d;
    logic signed [N-1:0] p_q, p_d;
    logic signed [N-1:0] i_q, i_d;
    logic signed [N-1:0] integ_q, integ_d;
    logic signed [N-1:0] uk_q, uk_d;
    logic                uk_valid_q, uk_valid_d;
    logic                busy_q, busy_d;

    logic signed [N-1:0] mul_a;
    logic signed [N-1:0] mul_y;

    fx_mul_sat #(.N(N), .F(F)) u_mul (
        .a (mul_a),
        .b (ek_q),
        .y (mul_y)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a tick is only honoured in IDLE, then the sequence runs to OUT.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_d = ST_MULP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MULP:  state_d = ST_MULI;
            ST_MULI:  state_d = ST_INTEG;
            ST_INTEG: state_d = ST_OUT;
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shared multiplier operand select: ki in MULI, kp otherwise.
    always_comb begin
        case (state_q)
            ST_MULI: mul_a = ki_q;
            default: mul_a = kp_q;
        endcase
    end

    // Datapath and output next values; the IDLE clear precedes capture so a same-cycle tick sees integ = 0.
    always_comb begin
        ek_d       = ek_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        p_d        = p_q;
        i_d        = i_q;
        integ_d    = integ_q;
        uk_d       = uk_q;
        uk_valid_d = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (int_clr) begin
                    integ_d = ZERO_L;
                end else begin
                    integ_d = integ_q;
                end
                if (sample_tick) begin
                    ek_d   = ek;
                    kp_d   = kp;
                    ki_d   = ki;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_MULP:  p_d     = mul_y;
            ST_MULI:  i_d     = mul_y;
            ST_INTEG: integ_d = sat_add(integ_q, i_q);
            ST_OUT: begin
                uk_d       = sat_add(p_q, integ_q);
                uk_valid_d = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ek_q       <= ZERO_L;
            kp_q       <= ZERO_L;
            ki_q       <= ZERO_L;
            p_q        <= ZERO_L;
            i_q        <= ZERO_L;
            integ_q    <= ZERO_L;
            uk_q       <= ZERO_L;
            uk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ek_q       <= ek_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            p_q        <= p_d;
            i_q        <= i_d;
            integ_q    <= integ_d;
            uk_q       <= uk_d;
            uk_valid_q <= uk_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign uk       = uk_q;
    assign uk_valid = uk_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pi_uk.sv
// Directed, table-driven bench for pi_uk with hand-computed expected outputs.
module tb_pi_uk;

    localparam int N = 18;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sample_tick;
    logic                int_clr;
    logic signed [N-1:0] ek, kp, ki;
    logic signed [N-1:0] uk;
    logic                uk_valid;
    logic                busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pi_uk dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .int_clr     (int_clr),
        .ek          (ek),
        .kp          (kp),
        .ki          (ki),
        .uk          (uk),
        .uk_valid    (uk_valid),
        .busy        (busy)
    );

    typedef struct {
        logic                clr;
        logic signed [N-1:0] ek;
        logic signed [N-1:0] kp;
        logic signed [N-1:0] ki;
        logic signed [N-1:0] exp_uk;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One sample: tick accepted at edge t, uk_valid expected at t+4; optional int_clr while busy.
    task automatic run_sample(input logic clr, input logic signed [N-1:0] e,
                              input logic signed [N-1:0] p, input logic signed [N-1:0] i,
                              input logic signed [N-1:0] exp, input logic clr_busy,
                              input string tag);
        @(negedge clk);
        ek = e; kp = p; ki = i; int_clr = clr; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        int_clr = clr_busy;
        check({tag, " busy@t"}, int'(busy), 1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("%s valid@t+%0d", tag, c), int'(uk_valid), 0);
            check($sformatf("%s busy@t+%0d", tag, c), int'(busy), 1);
        end
        int_clr = 1'b0;
        @(posedge clk); #1;
        check({tag, " valid@t+4"}, int'(uk_valid), 1);
        check({tag, " busy@t+4"}, int'(busy), 0);
        check({tag, " uk"}, int'(uk), int'(exp));
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{1'b0,  18'sd1024,    18'sd512,  18'sd256,    18'sd1536};
        vecs[1]  = '{1'b0,  18'sd1024,    18'sd512,  18'sd256,    18'sd2048};
        vecs[2]  = '{1'b0,  18'sd1024,    18'sd512,  18'sd256,    18'sd2560};
        vecs[3]  = '{1'b1, -18'sd1,       18'sd1,    18'sd0,     -18'sd1};
        vecs[4]  = '{1'b0,  18'sd1,       18'sd1,    18'sd0,      18'sd0};
        vecs[5]  = '{1'b0,  18'sd100000,  18'sd1024, 18'sd0,      18'sd131071};
        vecs[6]  = '{1'b0, -18'sd100000,  18'sd1024, 18'sd0,     -18'sd131072};
        vecs[7]  = '{1'b0,  18'sd1000,   -18'sd768,  18'sd0,     -18'sd1500};
        vecs[8]  = '{1'b0,  18'sd3,      -18'sd1,    18'sd0,     -18'sd1};
        vecs[9]  = '{1'b0,  18'sd131071,  18'sd0,    18'sd131071, 18'sd131071};
        vecs[10] = '{1'b0,  18'sd131071,  18'sd0,    18'sd131071, 18'sd131071};
        vecs[11] = '{1'b0, -18'sd512,     18'sd0,    18'sd512,    18'sd130559};
        vecs[12] = '{1'b1,  18'sd2048,    18'sd0,    18'sd512,    18'sd2048};
        vecs[13] = '{1'b1,  18'sd512,     18'sd0,    18'sd512,    18'sd512};

        rst_n = 1'b0; sample_tick = 1'b0; int_clr = 1'b0;
        ek = '0; kp = '0; ki = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset uk", int'(uk), 0);
        check("reset uk_valid", int'(uk_valid), 0);
        check("reset busy", int'(busy), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            run_sample(vecs[v].clr, vecs[v].ek, vecs[v].kp, vecs[v].ki,
                       vecs[v].exp_uk, 1'b0, $sformatf("vec%0d", v));
        end

        // int_clr during busy is ignored: integ stays 512.
        run_sample(1'b0, 18'sd0, 18'sd0, 18'sd0, 18'sd512, 1'b1, "clr_busy");
        run_sample(1'b0, 18'sd0, 18'sd0, 18'sd0, 18'sd512, 1'b0, "clr_busy_after");

        // Reset two cycles after an accepted tick discards the computation.
        @(negedge clk);
        ek = 18'sd1024; kp = 18'sd512; ki = 18'sd256; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst uk", int'(uk), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst uk_valid", int'(uk_valid), 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (uk_valid) pulses++;
        end
        check("midrst no pulse", pulses, 0);
        run_sample(1'b0, 18'sd512, 18'sd512, 18'sd0, 18'sd512, 1'b0, "post_rst");

        // Tick held high: accepted every 5 clocks, pulses at t+4, t+9, t+14.
        @(negedge clk);
        ek = 18'sd512; kp = 18'sd512; ki = 18'sd0; sample_tick = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 4 || k == 9 || k == 14) begin
                check($sformatf("b2b valid@t+%0d", k), int'(uk_valid), 1);
                check($sformatf("b2b busy@t+%0d", k), int'(busy), 0);
                check($sformatf("b2b uk@t+%0d", k), int'(uk), 512);
            end else begin
                check($sformatf("b2b valid@t+%0d", k), int'(uk_valid), 0);
                check($sformatf("b2b busy@t+%0d", k), int'(busy), 1);
            end
        end
        sample_tick = 1'b0;
        @(posedge clk); #1;
        check("b2b idle after release", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
